// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard/fetch side and the pipeline sequencer:
// stall/flush/fetch requests in, PC and pipeline-register controls out.
interface pipe_ctrl_if;
  logic stall_req;
  logic flush_req;
  logic fetch_valid;
  logic pc_en;
  logic pc_sel;
  logic ifid_en;
  logic idex_bubble;

  modport master (
    output stall_req, flush_req, fetch_valid,
    input  pc_en, pc_sel, ifid_en, idex_bubble
  );

  modport slave (
    input  stall_req, flush_req, fetch_valid,
    output pc_en, pc_sel, ifid_en, idex_bubble
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns stall/flush requests into stage enables and bubbles,
// tracks per-stage valid bits and keeps stall/flush/retire statistics.
module pipe_ctrl #(
  parameter int MAX_STALL = 12,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       ctl,
  output logic             valid_id,
  output logic             valid_ex,
  output logic             valid_mem,
  output logic             valid_wb,
  output logic             in_redirect,
  output logic [3:0]       stall_cnt,
  output logic             watchdog,
  output logic [CNT_W-1:0] stall_total,
  output logic [CNT_W-1:0] flush_total,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0]       MAX_STALL_W = 4'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             in_redirect_r;
  logic             valid_id_r, valid_ex_r, valid_mem_r, valid_wb_r;
  logic [3:0]       stall_cnt_r;
  logic [CNT_W-1:0] stall_total_r, flush_total_r, retired_r;
  logic             stall_eff_s;
  logic             pc_en_s, pc_sel_s, ifid_en_s, idex_bubble_s;

  // Same-cycle pipeline controls; flush outranks stall, and an empty ID slot cannot stall.
  always_comb begin
    stall_eff_s   = ctl.stall_req & valid_id_r & ~ctl.flush_req;
    pc_en_s       = ~stall_eff_s;
    pc_sel_s      = ctl.flush_req;
    ifid_en_s     = ~stall_eff_s;
    idex_bubble_s = stall_eff_s | ctl.flush_req | ~valid_id_r;
  end

  assign ctl.pc_en       = pc_en_s;
  assign ctl.pc_sel      = pc_sel_s;
  assign ctl.ifid_en     = ifid_en_s;
  assign ctl.idex_bubble = idex_bubble_s;

  // Stage valid bits; the flushing branch itself keeps moving from EX onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_id_r  <= 1'b0;
      valid_ex_r  <= 1'b0;
      valid_mem_r <= 1'b0;
      valid_wb_r  <= 1'b0;
    end else if (ctl.flush_req) begin
      valid_id_r  <= 1'b0;
      valid_ex_r  <= 1'b0;
      valid_mem_r <= valid_ex_r;
      valid_wb_r  <= valid_mem_r;
    end else if (stall_eff_s) begin
      valid_id_r  <= valid_id_r;
      valid_ex_r  <= 1'b0;
      valid_mem_r <= valid_ex_r;
      valid_wb_r  <= valid_mem_r;
    end else begin
      valid_id_r  <= ctl.fetch_valid;
      valid_ex_r  <= valid_id_r;
      valid_mem_r <= valid_ex_r;
      valid_wb_r  <= valid_mem_r;
    end
  end

  // Sequencer FSM with registered REDIRECT indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      in_redirect_r <= 1'b0;
    end else begin
      case (state_r)
        RUN, STALL, REDIRECT: begin
          if (ctl.flush_req) begin
            state_r       <= REDIRECT;
            in_redirect_r <= 1'b1;
          end else if (stall_eff_s) begin
            state_r       <= STALL;
            in_redirect_r <= 1'b0;
          end else begin
            state_r       <= RUN;
            in_redirect_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= RUN;
          in_redirect_r <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive-stall counter, saturating so the watchdog stays asserted on long stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 4'd0;
    end else if (stall_eff_s) begin
      if (stall_cnt_r != 4'd15) begin
        stall_cnt_r <= stall_cnt_r + 4'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end else begin
      stall_cnt_r <= 4'd0;
    end
  end

  // Free-running statistics; they wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_total_r <= {CNT_W{1'b0}};
      flush_total_r <= {CNT_W{1'b0}};
      retired_r     <= {CNT_W{1'b0}};
    end else begin
      stall_total_r <= stall_eff_s   ? stall_total_r + CNT_ONE : stall_total_r;
      flush_total_r <= ctl.flush_req ? flush_total_r + CNT_ONE : flush_total_r;
      retired_r     <= valid_wb_r    ? retired_r + CNT_ONE     : retired_r;
    end
  end

  assign valid_id    = valid_id_r;
  assign valid_ex    = valid_ex_r;
  assign valid_mem   = valid_mem_r;
  assign valid_wb    = valid_wb_r;
  assign in_redirect = in_redirect_r;
  assign stall_cnt   = stall_cnt_r;
  assign watchdog    = (stall_cnt_r >= MAX_STALL_W);
  assign stall_total = stall_total_r;
  assign flush_total = flush_total_r;
  assign retired     = retired_r;

endmodule
